// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: instruction-memory base address and the
// {pc, instr} entry carried through the prefetch queue.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IFU_IM_BASE  = IFU_RESET_PC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// DEPTH-entry prefetch FIFO with flush; the head entry and its valid flag are
// held in dedicated registers so consumers see no path from pop/flush.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  fetch_entry_t     wdata_i,
  output logic             head_vld_o,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  fetch_entry_t     head_q, head_d;
  logic             pop_ok, push_ok, remain;

  assign pop_ok  = pop_i && vld_q;
  assign push_ok = push_i && !flush_i && ((cnt_q != FULL) || pop_ok);
  // At least one stored entry survives this cycle's pop.
  assign remain  = (cnt_q > ONE) || ((cnt_q == ONE) && !pop_ok);

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    head_d = head_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      vld_d = 1'b0;
    end else begin
      if (pop_ok)  rd_d = rd_q + PTR_W'(1);
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (remain) begin
        head_d = mem_q[rd_d];
        vld_d  = 1'b1;
      end else if (push_ok) begin
        head_d = wdata_i;
        vld_d  = 1'b1;
      end else begin
        vld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  assign head_vld_o = vld_q;
  assign head_o     = head_q;
  assign count_o    = cnt_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, addresses the ROM, fills the
// prefetch queue and handles redirects. Optional macro IFU_BOUND_CHECK_EN.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_instr,
  output logic [31:0]       dec_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_fault
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d, target;
  logic             pop, space, want, push, in_range, fault_q;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head, wdata;

  assign target = redirect_pc & ~32'h3;
  assign pop    = dec_valid && dec_ready;
  assign space  = (count != CNT_W'(DEPTH)) || pop;
  assign want   = !redirect_valid && space;
  assign push   = want && in_range && !fault_q;
  assign wdata  = '{pc: pc_q, instr: imem_rdata};

`ifdef IFU_BOUND_CHECK_EN
  localparam logic [32:0] LIMIT = 33'(64'd1 << (ADDR_W + 2));

  logic [31:0] off, tgt_off;
  logic        tgt_in_range, fault_d;

  assign off          = pc_q - RESET_PC;
  assign tgt_off      = target - RESET_PC;
  assign in_range     = {1'b0, off} < LIMIT;
  assign tgt_in_range = {1'b0, tgt_off} < LIMIT;
  assign imem_addr    = off[ADDR_W+1:2];

  // Sticky until a redirect lands back inside the ROM window.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = fault_q && !tgt_in_range;
    else if (want && !in_range) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`else
  assign in_range  = 1'b1;
  assign fault_q   = 1'b0;
  assign imem_addr = ADDR_W'((pc_q - RESET_PC) >> 2);
`endif

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = target;
    else if (push)      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (wdata),
    .head_vld_o (dec_valid),
    .head_o     (head),
    .count_o    (count)
  );

  assign dec_instr   = head.instr;
  assign dec_pc      = head.pc;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a behavioural ROM (word i = C0DE_0000 | i).
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hC0DE_0000 | {22'd0, imem_addr};

  function automatic logic [31:0] rom(input int unsigned a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    tests_run++; if (dec_valid !== 1'b0) begin failed++; $display("FAIL rst_valid: got %b exp 0", dec_valid); end
    tests_run++; if (dec_pc !== 32'h0) begin failed++; $display("FAIL rst_pc: got %h exp 0", dec_pc); end
    tests_run++; if (dec_instr !== 32'h0) begin failed++; $display("FAIL rst_instr: got %h exp 0", dec_instr); end
    tests_run++; if (fetch_fault !== 1'b0) begin failed++; $display("FAIL rst_fault: got %b exp 0", fetch_fault); end
    step();
    reset = 1'b1;
    tests_run++; if (imem_addr !== 10'd0) begin failed++; $display("FAIL rst_c0_addr: got %0d exp 0", imem_addr); end
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h3000 + 32'(4 * i) || dec_instr !== rom(i)) begin
        failed++;
        $display("FAIL rst_stream%0d: got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                 i, dec_valid, dec_pc, dec_instr, 32'h3000 + 32'(4 * i), rom(i));
      end
    end
  endtask

  task automatic test_backpressure();
    dec_ready = 1'b0;
    do_redirect(32'h3000);
    tests_run++; if (dec_valid !== 1'b0 || imem_addr !== 10'd0) begin failed++; $display("FAIL bp_flush: got v=%b addr=%0d exp v=0 addr=0", dec_valid, imem_addr); end
    for (int i = 0; i < 10; i++) step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3000 || dec_instr !== rom(0)) begin failed++; $display("FAIL bp_head: got v=%b pc=%h exp v=1 pc=3000", dec_valid, dec_pc); end
    tests_run++; if (imem_addr !== 10'd4) begin failed++; $display("FAIL bp_pc_stall: got addr=%0d exp 4", imem_addr); end
    tests_run++; if (dut.u_fifo.count_o !== 3'd4) begin failed++; $display("FAIL bp_count: got %0d exp 4", dut.u_fifo.count_o); end
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h3000 + 32'(4 * i) || dec_instr !== rom(i)) begin
        failed++;
        $display("FAIL bp_drain%0d: got v=%b pc=%h exp v=1 pc=%h", i, dec_valid, dec_pc, 32'h3000 + 32'(4 * i));
      end
      step();
    end
  endtask

  task automatic test_redirect();
    dec_ready = 1'b0;
    do_redirect(32'h3000);
    for (int i = 0; i < 6; i++) step();
    do_redirect(32'h3043);
    tests_run++; if (dec_valid !== 1'b0 || imem_addr !== 10'd16) begin failed++; $display("FAIL rd_n1: got v=%b addr=%0d exp v=0 addr=16", dec_valid, imem_addr); end
    step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3040 || dec_instr !== rom(16)) begin failed++; $display("FAIL rd_n2: got v=%b pc=%h instr=%h exp v=1 pc=3040 instr=%h", dec_valid, dec_pc, dec_instr, rom(16)); end
    dec_ready = 1'b1;
    step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3044 || dec_instr !== rom(17)) begin failed++; $display("FAIL rd_n3: got v=%b pc=%h exp v=1 pc=3044", dec_valid, dec_pc); end
  endtask

  task automatic test_redirect_pop();
    dec_ready = 1'b0;
    do_redirect(32'h3000);
    for (int i = 0; i < 6; i++) step();
    dec_ready = 1'b1;
    do_redirect(32'h3100);
    tests_run++; if (dec_valid !== 1'b0) begin failed++; $display("FAIL rp_n1: got v=%b pc=%h exp v=0", dec_valid, dec_pc); end
    step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3100 || dec_instr !== rom(64)) begin failed++; $display("FAIL rp_n2: got v=%b pc=%h exp v=1 pc=3100", dec_valid, dec_pc); end
    step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3104) begin failed++; $display("FAIL rp_n3: got v=%b pc=%h exp v=1 pc=3104", dec_valid, dec_pc); end
  endtask

  task automatic test_wrap();
    dec_ready = 1'b1;
    do_redirect(32'h3FFC);
    tests_run++; if (imem_addr !== 10'd1023 || dec_valid !== 1'b0) begin failed++; $display("FAIL wr_addr1023: got addr=%0d v=%b exp 1023 v=0", imem_addr, dec_valid); end
    step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3FFC || dec_instr !== rom(1023)) begin failed++; $display("FAIL wr_head3ffc: got v=%b pc=%h exp v=1 pc=3ffc", dec_valid, dec_pc); end
    tests_run++; if (imem_addr !== 10'd0) begin failed++; $display("FAIL wr_addr0: got %0d exp 0", imem_addr); end
    step();
`ifdef IFU_BOUND_CHECK_EN
    tests_run++; if (dec_valid !== 1'b0 || fetch_fault !== 1'b1) begin failed++; $display("FAIL wr_fault: got v=%b fault=%b exp v=0 fault=1", dec_valid, fetch_fault); end
    step();
    tests_run++; if (dec_valid !== 1'b0 || fetch_fault !== 1'b1) begin failed++; $display("FAIL wr_halt: got v=%b fault=%b exp v=0 fault=1", dec_valid, fetch_fault); end
    do_redirect(32'h3000);
    tests_run++; if (fetch_fault !== 1'b0) begin failed++; $display("FAIL wr_fault_clr: got %b exp 0", fetch_fault); end
    step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3000) begin failed++; $display("FAIL wr_restart: got v=%b pc=%h exp v=1 pc=3000", dec_valid, dec_pc); end
`else
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4000 || dec_instr !== rom(0)) begin failed++; $display("FAIL wr_head4000: got v=%b pc=%h instr=%h exp v=1 pc=4000 instr=%h", dec_valid, dec_pc, dec_instr, rom(0)); end
    tests_run++; if (fetch_fault !== 1'b0) begin failed++; $display("FAIL wr_nofault: got %b exp 0", fetch_fault); end
`endif
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    do_redirect(32'h3020);
    for (int i = 0; i < 3; i++) step();
    #2;
    reset = 1'b0;
    #1;
    tests_run++; if (dec_valid !== 1'b0 || dut.u_fifo.count_o !== 3'd0) begin failed++; $display("FAIL ar_clear: got v=%b count=%0d exp v=0 count=0", dec_valid, dut.u_fifo.count_o); end
    tests_run++; if (imem_addr !== 10'd0 || dec_pc !== 32'h0) begin failed++; $display("FAIL ar_pc: got addr=%0d pc=%h exp addr=0 pc=0", imem_addr, dec_pc); end
    dec_ready = 1'b1;
    step();
    reset = 1'b1;
    tests_run++; if (imem_addr !== 10'd0) begin failed++; $display("FAIL ar_c0_addr: got %0d exp 0", imem_addr); end
    step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3000 || dec_instr !== rom(0)) begin failed++; $display("FAIL ar_c1: got v=%b pc=%h exp v=1 pc=3000", dec_valid, dec_pc); end
    step();
    tests_run++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3004) begin failed++; $display("FAIL ar_c2: got v=%b pc=%h exp v=1 pc=3004", dec_valid, dec_pc); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
